// File: rtl/store_rmw_seq.sv
// store_rmw_seq: multicycle read-modify-write sequencer for SW/SH/SB stores.
// Word stores write straight through. Half-word and byte stores first read the
// target word, then merge the low half/byte of B into it, then write it back.
// Every output is a flop loaded from next-state decode, so there is no
// combinational path from any input to any output.
module store_rmw_seq #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] b_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 2;
    localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [TYPE_W-1:0] ST_SW    = 2'b00;
    localparam logic [TYPE_W-1:0] ST_SH    = 2'b01;
    localparam logic [TYPE_W-1:0] ST_SB    = 2'b10;
    localparam logic [TYPE_W-1:0] ST_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [TYPE_W-1:0]   r_type;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_mdr;
    logic [CNT_W-1:0]    r_cnt;

    logic [TYPE_W-1:0]   w_type_nxt;
    logic [DATA_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_b_nxt;
    logic [DATA_W-1:0]   w_mdr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [DATA_W-1:0]   r_mem_addr;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [DATA_W-1:0]   w_mem_addr_nxt;
    logic                w_mem_rd_nxt;
    logic                w_mem_wr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    // Merge the low sub-word of B into the captured memory word.
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [TYPE_W-1:0] t,
        input logic [DATA_W-1:0] mdr,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        case (t)
            ST_SH:   res = {mdr[31:16], b[15:0]};
            ST_SB:   res = {mdr[31:8],  b[7:0]};
            default: res = b;
        endcase
        return res;
    endfunction

    // State register and request latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_type  <= '0;
            r_addr  <= '0;
            r_b     <= '0;
            r_mdr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_type  <= w_type_nxt;
            r_addr  <= w_addr_nxt;
            r_b     <= w_b_nxt;
            r_mdr   <= w_mdr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, latch update and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_type_nxt  = r_type;
        w_addr_nxt  = r_addr;
        w_b_nxt     = r_b;
        w_mdr_nxt   = r_mdr;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_IDLE, S_FIN: begin
                if (start) begin
                    w_type_nxt = store_type;
                    w_addr_nxt = addr;
                    w_b_nxt    = b_data;
                    case (store_type)
                        ST_SW:   w_state_nxt = S_WR;
                        ST_SH:   w_state_nxt = S_RD;
                        ST_SB:   w_state_nxt = S_RD;
                        default: w_state_nxt = S_FIN;
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                w_cnt_nxt   = CNT_LOAD;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_mdr_nxt   = mem_rdata;
                    w_state_nxt = S_WR;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_WR: begin
                w_state_nxt = S_FIN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are a pure function of the next state and next latches.
        w_mem_rd_nxt    = (w_state_nxt == S_RD);
        w_mem_wr_nxt    = (w_state_nxt == S_WR);
        w_busy_nxt      = (w_state_nxt == S_RD) || (w_state_nxt == S_WAIT) ||
                          (w_state_nxt == S_WR);
        w_done_nxt      = (w_state_nxt == S_FIN);
        w_err_nxt       = (w_state_nxt == S_FIN) && (w_type_nxt == ST_RSVD);
        w_mem_addr_nxt  = w_busy_nxt ? w_addr_nxt : '0;
        w_mem_wdata_nxt = w_mem_wr_nxt ? f_merge(w_type_nxt, w_mdr_nxt, w_b_nxt) : '0;
    end

    // Output registers; reset clears them at once, abandoning any write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_store_rmw_seq.sv
// Testbench for store_rmw_seq: table-driven store sequences on two instances
// (MEM_LATENCY 1 and 3) plus hand-written reset and back-to-back sequences.
module tb_store_rmw_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] b_data;
    logic [31:0] mem_rdata;

    logic [31:0] a1, a3, wd1, wd3;
    logic        rd1, rd3, wr1, wr3, bz1, bz3, dn1, dn3, er1, er3;

    logic        sel3;
    logic [31:0] o_addr, o_wdata;
    logic        o_rd, o_wr, o_busy, o_done, o_err;

    int n_checks;
    int n_fail;

    store_rmw_seq #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .store_type(store_type),
        .addr(addr), .b_data(b_data), .mem_rdata(mem_rdata),
        .mem_addr(a1), .mem_rd(rd1), .mem_wr(wr1), .mem_wdata(wd1),
        .busy(bz1), .done(dn1), .err(er1)
    );

    store_rmw_seq #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .store_type(store_type),
        .addr(addr), .b_data(b_data), .mem_rdata(mem_rdata),
        .mem_addr(a3), .mem_rd(rd3), .mem_wr(wr3), .mem_wdata(wd3),
        .busy(bz3), .done(dn3), .err(er3)
    );

    assign o_addr  = sel3 ? a3  : a1;
    assign o_wdata = sel3 ? wd3 : wd1;
    assign o_rd    = sel3 ? rd3 : rd1;
    assign o_wr    = sel3 ? wr3 : wr1;
    assign o_busy  = sel3 ? bz3 : bz1;
    assign o_done  = sel3 ? dn3 : dn1;
    assign o_err   = sel3 ? er3 : er1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] b;
        logic [31:0] rdata;
        logic [31:0] wdata;
        int          wr_cyc;
        int          done_cyc;
        logic        err;
        logic        lat3;
        logic        perturb;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic e_rd,
                           input logic e_wr, input logic [31:0] e_wdata, input logic e_busy,
                           input logic e_done, input logic e_err);
        chk({tag, " mem_addr"},  o_addr,  e_addr);
        chk({tag, " mem_rd"},    32'(o_rd),   32'(e_rd));
        chk({tag, " mem_wr"},    32'(o_wr),   32'(e_wr));
        chk({tag, " mem_wdata"}, o_wdata, e_wdata);
        chk({tag, " busy"},      32'(o_busy), 32'(e_busy));
        chk({tag, " done"},      32'(o_done), 32'(e_done));
        chk({tag, " err"},       32'(o_err),  32'(e_err));
        chk({tag, " rd_wr_excl"}, 32'(o_rd & o_wr), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic e_rd, e_wr, e_done, e_busy, e_err;
        logic [31:0] e_addr, e_wdata;

        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        start      = 1'b0;
        store_type = 2'b00;
        addr       = '0;
        b_data     = '0;
        mem_rdata  = '0;
        sel3       = 1'b0;

        //            st     addr          b             rdata         wdata         wr dn err lat3 pert
        vecs[0] = '{2'b00, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1, 2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 32'h0000_0044, 32'hAAAA_5566, 32'h1122_3344, 32'h1122_5566, 3, 4, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{2'b10, 32'h0000_0048, 32'h0000_00FF, 32'hCAFE_BABE, 32'hCAFE_BAFF, 5, 6, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{2'b11, 32'h0000_004C, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 0, 1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 32'h0000_0050, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 5, 6, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 32'h0000_0054, 32'h1234_5600, 32'hFFFF_FFFF, 32'hFFFF_FF00, 3, 4, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 2, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2'b01, 32'h0000_0003, 32'h0000_ABCD, 32'h0000_0000, 32'h0000_ABCD, 3, 4, 1'b0, 1'b0, 1'b0};

        // Reset state on both instances.
        #2;
        sel3 = 1'b0;
        #1 chk_all("reset lat1", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        sel3 = 1'b1;
        #1 chk_all("reset lat3", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven single sequences.
        for (int i = 0; i < NV; i++) begin
            v          = vecs[i];
            sel3       = v.lat3;
            store_type = v.st;
            addr       = v.addr;
            b_data     = v.b;
            mem_rdata  = v.rdata;
            start      = 1'b1;
            for (int c = 1; c <= v.done_cyc + 1; c++) begin
                @(posedge clk);
                #1;
                e_rd    = (c == 1) && (v.st == 2'b01 || v.st == 2'b10);
                e_wr    = (c == v.wr_cyc);
                e_done  = (c == v.done_cyc);
                e_busy  = (c < v.done_cyc);
                e_err   = e_done && v.err;
                e_addr  = (c <= v.wr_cyc) ? v.addr : 32'h0;
                e_wdata = e_wr ? v.wdata : 32'h0;
                chk_all($sformatf("v%0d c%0d", i, c), e_addr, e_rd, e_wr, e_wdata,
                        e_busy, e_done, e_err);
                if (c == 1) begin
                    start = v.perturb;
                    if (v.perturb) begin
                        b_data     = ~v.b;
                        addr       = ~v.addr;
                        store_type = 2'b00;
                    end
                end
                if (c == 3) start = 1'b0;
            end
            repeat (6) @(posedge clk);
            #1;
        end

        // Reset asserted during the WR cycle of an SH.
        sel3       = 1'b0;
        store_type = 2'b01;
        addr       = 32'h0000_0080;
        b_data     = 32'hAAAA_5566;
        mem_rdata  = 32'h1122_3344;
        start      = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("rst wr before", 32'(o_wr), 32'd1);
        chk("rst wdata before", o_wdata, 32'h1122_5566);
        #2 reset = 1'b0;
        #1 chk_all("rst async", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 chk_all($sformatf("rst idle%0d", c), 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        store_type = 2'b00;
        addr       = 32'h0000_0090;
        b_data     = 32'h5A5A_A5A5;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk_all("rst resume c1", 32'h0000_0090, 1'b0, 1'b1, 32'h5A5A_A5A5, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk_all("rst resume c2", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back SW with start held through FIN.
        sel3       = 1'b0;
        store_type = 2'b00;
        addr       = 32'h0000_0100;
        b_data     = 32'h1111_1111;
        start      = 1'b1;
        @(posedge clk);
        #1 chk_all("b2b c1", 32'h0000_0100, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        addr   = 32'h0000_0104;
        b_data = 32'h2222_2222;
        @(posedge clk);
        #1 chk_all("b2b c2", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 chk_all("b2b c3", 32'h0000_0104, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        @(posedge clk);
        #1 chk_all("b2b c4", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 chk_all("b2b c5", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
